lsu_bus_adapter: RTL and testbench
==================================

# lsu_bus_adapter

Parametrised load/store unit that replaces direct combinational memory access with a registered, handshaked bus master. It accepts one load or store per transaction from the execute/memory stage, then issues an aligned AXI-lite-style read or write. It returns sign- or zero-extended load data, or a store completion, with an error flag. It sits between the core's memory stage and the data-side memory interconnect.

## Interface
- XLEN, 64, data width in bits; legal values 32 or 64
- ADDR_W, 64, address width in bits
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword is legal only when XLEN = 64)
- req_signed  in  1  sign-extend load result
- resp_valid / resp_ready  out / in  1  response handshake
- resp_rdata  out  XLEN  extended load data; 0 for stores and on error
- resp_err  out  1  misaligned access, illegal size, or bus error
- ar_valid, ar_ready, ar_addr[ADDR_W]  read address channel
- r_valid, r_ready, r_data[XLEN], r_resp[2]  read data channel
- aw_valid, aw_ready, aw_addr[ADDR_W]  write address channel
- w_valid, w_ready, w_data[XLEN], w_strb[XLEN/8]  write data channel
- b_valid, b_ready, b_resp[2]  write response channel

## Operation
- Definitions:
  - OFF = req_addr[log2(XLEN/8)-1:0].
  - Bus address = req_addr with the OFF bits cleared.
  - All request fields are latched on acceptance.
- States:
  - IDLE: req_ready = 1. On accept:
    - misaligned (addr not a multiple of 1<<size) or illegal size → RESP with err = 1, no bus activity.
    - otherwise, load → RD_ADDR; store → WR_REQ.
  - RD_ADDR: ar_valid = 1. On ar_ready → RD_DATA.
  - RD_DATA: r_ready = 1. On r_valid, latch the response → RESP.
    - Extraction: shift r_data right by OFF*8, keep the low 8<<size bits, then sign- or zero-extend to XLEN per req_signed.
    - err = (r_resp != 0). On error, rdata = 0.
  - WR_REQ: aw_valid and w_valid are both raised.
    - Each valid drops independently after its own handshake, tracked with aw_done and w_done flags.
    - w_strb = ((1<<(1<<size)) − 1) << OFF.
    - w_data = req_wdata << OFF*8.
    - When both handshakes are done → WR_RESP.
  - WR_RESP: b_ready = 1. On b_valid, err = (b_resp != 0) → RESP.
  - RESP: resp_valid = 1. resp_rdata and resp_err are held stable. On resp_ready → IDLE.
- Only one transaction is outstanding at a time; no new request is accepted before the response handshake completes.
- Bus outputs (valid, addr, data, strb) are registered and remain stable while their valid is high and ready is low.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1.
  - All other valid/ready outputs = 0: resp_valid, ar_valid, aw_valid, w_valid, r_ready, b_ready.
  - resp_rdata = 0, resp_err = 0, ar_addr = aw_addr = w_data = w_strb = 0.
- Reset mid-operation: every output returns to its reset value immediately (asynchronously), and the transaction is abandoned. After reset deasserts, the first accept can happen on the first rising edge.
- Zero-wait-state load: accept at edge 0; ar_valid high in cycle 1; r_valid sampled in cycle 2; resp_valid high in cycle 3.
- Zero-wait-state store: accept at edge 0; aw_valid and w_valid high in cycle 1; b_valid sampled in cycle 2; resp_valid high in cycle 3.
- Misaligned or illegal request: resp_valid high in the cycle after accept.
- aw and w handshakes may complete in the same cycle or in different cycles, in either order.
- r_valid or b_valid arriving while the unit is not in RD_DATA/WR_RESP cannot occur; it is ignored.
- Back-pressure: while resp_ready = 0, resp_* are held and req_ready = 0.

## Test plan
- Load byte, XLEN = 64:
  - Request: lb signed at addr 0x8000_0003; slave returns r_data = 0x1122_3344_8566_7788.
  - Expect ar_addr = 0x8000_0000, resp_rdata = 0xFFFF_FFFF_FFFF_FF85, err = 0, resp_valid in cycle 3.
  - Repeat with lbu: expect 0x85.
- Store half:
  - Request: sh addr 0x8000_0006, wdata 0xABCD.
  - Expect aw_addr = 0x8000_0000, w_strb = 0xC0, w_data = 0xABCD_0000_0000_0000, then resp_valid with err = 0.
- Misaligned load:
  - Request: lw at 0x8000_0002.
  - Expect ar_valid never asserted, resp_valid 1 cycle after accept, err = 1, rdata = 0.
- Staggered store channels and bus error:
  - Stimulus: aw_ready immediate, w_ready delayed 3 cycles, b_resp = 2.
  - Expect aw_valid dropped after 1 cycle, w_valid held 4 cycles, resp_err = 1.
- Back-pressure:
  - Stimulus: resp_ready low for 5 cycles after resp_valid.
  - Expect resp fields stable and req_ready = 0 throughout, then return to IDLE one cycle after resp_ready.
- Reset mid-operation:
  - Stimulus: assert reset in RD_DATA.
  - Expect r_ready and resp_valid to drop without a clock edge, req_ready = 1, and a fresh load to complete normally afterward.

Source files
------------

// File: rtl/lsu_bus_adapter_if.sv
// Bundles for the load/store adapter: core-side request/response channel and
// the AXI-lite-style data-side bus. The adapter is the slave of the first and the master of the second.

interface lsu_req_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [1:0]        req_size;
   logic              req_signed;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_axi_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic              r_valid;
   logic              r_ready;
   logic [XLEN-1:0]   r_data;
   logic [1:0]        r_resp;
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic              w_valid;
   logic              w_ready;
   logic [XLEN-1:0]   w_data;
   logic [XLEN/8-1:0] w_strb;
   logic              b_valid;
   logic              b_ready;
   logic [1:0]        b_resp;

   modport master (
      output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bus master: one outstanding access, aligned bus beats,
// lane shifting for stores and sign/zero extension for loads.

module lsu_bus_adapter #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic      clock,
   input  logic      reset,
   lsu_req_if.slave  core,
   lsu_axi_if.master bus
);
   localparam int NBYTES = XLEN / 8;
   localparam int OFF_W  = $clog2(NBYTES);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [NBYTES-1:0] strb_q, strb_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;

   // Request decode, evaluated only while IDLE accepts.
   logic [OFF_W-1:0]  req_off;
   logic [3:0]        align_mask;
   logic [3:0]        size_bytes;
   logic              misaligned;
   logic              illegal_size;
   logic [NBYTES-1:0] req_strb;

   always_comb begin
      req_off      = core.req_addr[OFF_W-1:0];
      align_mask   = (4'd1 << core.req_size) - 4'd1;
      size_bytes   = 4'd1 << core.req_size;
      misaligned   = |(core.req_addr[3:0] & align_mask);
      illegal_size = (XLEN == 32) && (core.req_size == 2'd3);
      req_strb     = '0;
      for (int b = 0; b < NBYTES; b++) begin
         req_strb[b] = (b >= int'(req_off)) && (b < int'(req_off) + int'(size_bytes));
      end
   end

   // Load lane extraction from the aligned read beat.
   logic [XLEN-1:0] r_shifted;
   logic [XLEN-1:0] r_ext;
   logic [6:0]      n_bits;
   logic            sign_bit;

   always_comb begin
      r_shifted = bus.r_data >> {off_q, 3'b000};
      n_bits    = 7'd8 << size_q;
      sign_bit  = 1'b0;
      r_ext     = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == int'(n_bits) - 1) sign_bit = signed_q & r_shifted[i];
      end
      for (int i = 0; i < XLEN; i++) begin
         r_ext[i] = (i < int'(n_bits)) ? r_shifted[i] : sign_bit;
      end
   end

   // NOTE: every _d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      off_d     = off_q;
      size_d    = size_q;
      signed_d  = signed_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (core.req_valid) begin
               off_d    = req_off;
               size_d   = core.req_size;
               signed_d = core.req_signed;
               rdata_d  = '0;
               err_d    = 1'b0;
               if (misaligned || illegal_size) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  addr_d  = {core.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  if (core.req_wen) begin
                     wdata_d   = core.req_wdata << {req_off, 3'b000};
                     strb_d    = req_strb;
                     aw_done_d = 1'b0;
                     w_done_d  = 1'b0;
                     state_d   = WR_REQ;
                  end else begin
                     state_d = RD_ADDR;
                  end
               end
            end
         end

         RD_ADDR: begin
            if (bus.ar_ready) state_d = RD_DATA;
         end

         RD_DATA: begin
            if (bus.r_valid) begin
               err_d   = (bus.r_resp != 2'b00);
               rdata_d = (bus.r_resp != 2'b00) ? '0 : r_ext;
               state_d = RESP;
            end
         end

         WR_REQ: begin
            // Address and data channels complete independently, in any order.
            if (!aw_done_q && bus.aw_ready) aw_done_d = 1'b1;
            if (!w_done_q && bus.w_ready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end

         WR_RESP: begin
            if (bus.b_valid) begin
               err_d   = (bus.b_resp != 2'b00);
               rdata_d = '0;
               state_d = RESP;
            end
         end

         RESP: begin
            if (core.resp_ready) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         off_q     <= '0;
         size_q    <= '0;
         signed_q  <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         off_q     <= off_d;
         size_q    <= size_d;
         signed_q  <= signed_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Handshake outputs are pure decodes of registered state, so reset clears them at once.
   assign core.req_ready  = (state_q == IDLE);
   assign core.resp_valid = (state_q == RESP);
   assign core.resp_rdata = rdata_q;
   assign core.resp_err   = err_q;

   assign bus.ar_valid = (state_q == RD_ADDR);
   assign bus.ar_addr  = addr_q;
   assign bus.r_ready  = (state_q == RD_DATA);
   assign bus.aw_valid = (state_q == WR_REQ) && !aw_done_q;
   assign bus.aw_addr  = addr_q;
   assign bus.w_valid  = (state_q == WR_REQ) && !w_done_q;
   assign bus.w_data   = wdata_q;
   assign bus.w_strb   = strb_q;
   assign bus.b_ready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Self-checking bench for lsu_bus_adapter (XLEN = 64): directed test-plan cases
// plus randomized transactions against an arithmetic reference model.

module tb_lsu_bus_adapter;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;

   logic clock;
   logic reset;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   lsu_req_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) req_if ();
   lsu_axi_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) axi_if ();

   lsu_bus_adapter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .core  (req_if),
      .bus   (axi_if)
   );

   int          n_checks;
   int          n_pass;
   int          lat;
   int          obs_aw_cycles;
   int          obs_w_cycles;
   logic [63:0] obs_addr;
   logic [63:0] obs_rdata;
   logic        obs_err;
   logic [63:0] obs_wdata;
   logic [7:0]  obs_strb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference model: plain arithmetic on the byte offset and access size.
   function automatic bit model_misaligned(input logic [63:0] addr, input logic [1:0] size);
      return (addr % (64'd1 << size)) != 0;
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] beat, input int off,
                                              input logic [1:0] size, input bit sgn);
      int          nbits;
      logic [63:0] mask;
      logic [63:0] v;
      nbits = 8 << size;
      mask  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
      v     = (beat >> (8 * off)) & mask;
      if (sgn && v[nbits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] model_strb(input int off, input logic [1:0] size);
      int m;
      m = ((1 << (1 << size)) - 1) << off;
      return m[7:0];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_txn(input string tag, input bit wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input bit sgn,
                          input logic [63:0] beat, input logic [1:0] bus_resp,
                          input int ar_dly, input int r_dly, input int aw_dly,
                          input int w_dly, input int b_dly, input int resp_dly);
      logic [63:0] exp_addr;
      logic [63:0] exp_rdata;
      logic        exp_err;
      int          off;
      int          cyc;
      int          last;
      off      = int'(addr[2:0]);
      exp_addr = addr & ~64'h7;
      obs_aw_cycles = 0;
      obs_w_cycles  = 0;

      check({tag, ".req_ready_idle"}, req_if.req_ready, 1'b1);
      req_if.req_valid  = 1'b1;
      req_if.req_wen    = wen;
      req_if.req_addr   = addr;
      req_if.req_wdata  = wdata;
      req_if.req_size   = size;
      req_if.req_signed = sgn;
      tick();
      // Scramble the request fields so a design that fails to latch them shows up.
      req_if.req_valid  = 1'b0;
      req_if.req_wen    = ~wen;
      req_if.req_addr   = {$urandom, $urandom};
      req_if.req_wdata  = {$urandom, $urandom};
      req_if.req_size   = 2'($urandom_range(0, 3));
      req_if.req_signed = ~sgn;
      cyc = 1;

      if (model_misaligned(addr, size)) begin
         exp_err   = 1'b1;
         exp_rdata = '0;
      end else if (!wen) begin
         for (int c = 0; c <= ar_dly; c++) begin
            check({tag, ".ar_valid"}, axi_if.ar_valid, 1'b1);
            check({tag, ".ar_addr"}, axi_if.ar_addr, exp_addr);
            check({tag, ".req_ready_busy"}, req_if.req_ready, 1'b0);
            obs_addr = axi_if.ar_addr;
            axi_if.ar_ready = (c == ar_dly);
            tick();
            cyc++;
         end
         axi_if.ar_ready = 1'b0;
         for (int c = 0; c <= r_dly; c++) begin
            check({tag, ".r_ready"}, axi_if.r_ready, 1'b1);
            check({tag, ".ar_valid_off"}, axi_if.ar_valid, 1'b0);
            axi_if.r_valid = (c == r_dly);
            axi_if.r_data  = (c == r_dly) ? beat : {$urandom, $urandom};
            axi_if.r_resp  = (c == r_dly) ? bus_resp : 2'($urandom_range(0, 3));
            tick();
            cyc++;
         end
         axi_if.r_valid = 1'b0;
         exp_err   = (bus_resp != 2'b00);
         exp_rdata = exp_err ? 64'd0 : model_load(beat, off, size, sgn);
      end else begin
         last = (aw_dly > w_dly) ? aw_dly : w_dly;
         for (int c = 0; c <= last; c++) begin
            check({tag, ".aw_valid"}, axi_if.aw_valid, (c <= aw_dly));
            check({tag, ".w_valid"}, axi_if.w_valid, (c <= w_dly));
            if (c <= aw_dly) check({tag, ".aw_addr"}, axi_if.aw_addr, exp_addr);
            if (c <= w_dly) begin
               check({tag, ".w_data"}, axi_if.w_data, wdata << (8 * off));
               check({tag, ".w_strb"}, axi_if.w_strb, model_strb(off, size));
            end
            if (axi_if.aw_valid) obs_aw_cycles++;
            if (axi_if.w_valid)  obs_w_cycles++;
            obs_addr  = axi_if.aw_addr;
            obs_wdata = axi_if.w_data;
            obs_strb  = axi_if.w_strb;
            axi_if.aw_ready = (c == aw_dly);
            axi_if.w_ready  = (c == w_dly);
            tick();
            cyc++;
         end
         axi_if.aw_ready = 1'b0;
         axi_if.w_ready  = 1'b0;
         for (int c = 0; c <= b_dly; c++) begin
            check({tag, ".b_ready"}, axi_if.b_ready, 1'b1);
            check({tag, ".aw_w_idle"}, {axi_if.aw_valid, axi_if.w_valid}, 2'b00);
            axi_if.b_valid = (c == b_dly);
            axi_if.b_resp  = (c == b_dly) ? bus_resp : 2'($urandom_range(0, 3));
            tick();
            cyc++;
         end
         axi_if.b_valid = 1'b0;
         exp_err   = (bus_resp != 2'b00);
         exp_rdata = '0;
      end

      lat = cyc;
      for (int c = 0; c <= resp_dly; c++) begin
         check({tag, ".resp_valid"}, req_if.resp_valid, 1'b1);
         check({tag, ".resp_rdata"}, req_if.resp_rdata, exp_rdata);
         check({tag, ".resp_err"}, req_if.resp_err, exp_err);
         check({tag, ".req_ready_resp"}, req_if.req_ready, 1'b0);
         check({tag, ".bus_quiet"}, {axi_if.ar_valid, axi_if.aw_valid, axi_if.w_valid}, 3'b000);
         obs_rdata = req_if.resp_rdata;
         obs_err   = req_if.resp_err;
         req_if.resp_ready = (c == resp_dly);
         tick();
      end
      req_if.resp_ready = 1'b0;
      check({tag, ".resp_valid_done"}, req_if.resp_valid, 1'b0);
      check({tag, ".req_ready_back"}, req_if.req_ready, 1'b1);
   endtask

   initial begin
      logic        r_wen;
      logic [1:0]  r_size;
      logic [63:0] r_addr;
      int          r_off;
      n_checks = 0;
      n_pass   = 0;

      req_if.req_valid  = 1'b0;
      req_if.req_wen    = 1'b0;
      req_if.req_addr   = '0;
      req_if.req_wdata  = '0;
      req_if.req_size   = '0;
      req_if.req_signed = 1'b0;
      req_if.resp_ready = 1'b0;
      axi_if.ar_ready = 1'b0;
      axi_if.r_valid  = 1'b0;
      axi_if.r_data   = '0;
      axi_if.r_resp   = '0;
      axi_if.aw_ready = 1'b0;
      axi_if.w_ready  = 1'b0;
      axi_if.b_valid  = 1'b0;
      axi_if.b_resp   = '0;

      reset = 1'b1;
      #2;
      check("rst.req_ready", req_if.req_ready, 1'b1);
      check("rst.valids", {req_if.resp_valid, axi_if.ar_valid, axi_if.aw_valid,
                           axi_if.w_valid, axi_if.r_ready, axi_if.b_ready}, 6'b0);
      check("rst.resp_rdata", req_if.resp_rdata, 64'd0);
      check("rst.resp_err", req_if.resp_err, 1'b0);
      check("rst.ar_addr", axi_if.ar_addr, 64'd0);
      check("rst.aw_addr", axi_if.aw_addr, 64'd0);
      check("rst.w_data", axi_if.w_data, 64'd0);
      check("rst.w_strb", axi_if.w_strb, 8'd0);
      tick();
      tick();
      reset = 1'b0;

      run_txn("lb", 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1, 64'h1122_3344_8566_7788, 2'd0,
              0, 0, 0, 0, 0, 0);
      check("lb.pin_addr", obs_addr, 64'h8000_0000);
      check("lb.pin_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_FF85);
      check("lb.pin_err", obs_err, 1'b0);
      check("lb.pin_latency", lat, 3);

      run_txn("lbu", 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0, 64'h1122_3344_8566_7788, 2'd0,
              0, 0, 0, 0, 0, 0);
      check("lbu.pin_rdata", obs_rdata, 64'h85);

      run_txn("sh", 1'b1, 64'h8000_0006, 64'hABCD, 2'd1, 1'b0, 64'd0, 2'd0,
              0, 0, 0, 0, 0, 0);
      check("sh.pin_addr", obs_addr, 64'h8000_0000);
      check("sh.pin_strb", obs_strb, 8'hC0);
      check("sh.pin_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
      check("sh.pin_err", obs_err, 1'b0);
      check("sh.pin_latency", lat, 3);

      run_txn("lw_mis", 1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, 64'd0, 2'd0,
              0, 0, 0, 0, 0, 0);
      check("lw_mis.pin_err", obs_err, 1'b1);
      check("lw_mis.pin_rdata", obs_rdata, 64'd0);
      check("lw_mis.pin_latency", lat, 1);

      run_txn("stagger", 1'b1, 64'h8000_0014, 64'h1234_5678, 2'd2, 1'b0, 64'd0, 2'd2,
              0, 0, 0, 3, 1, 0);
      check("stagger.pin_aw_cycles", obs_aw_cycles, 1);
      check("stagger.pin_w_cycles", obs_w_cycles, 4);
      check("stagger.pin_err", obs_err, 1'b1);
      check("stagger.pin_strb", obs_strb, 8'hF0);

      run_txn("bp", 1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 2'd0,
              1, 2, 0, 0, 0, 5);
      check("bp.pin_rdata", obs_rdata, 64'hDEAD_BEEF_0BAD_F00D);

      // Reset while waiting for read data.
      req_if.req_valid = 1'b1;
      req_if.req_wen   = 1'b0;
      req_if.req_addr  = 64'h8000_0020;
      req_if.req_size  = 2'd2;
      tick();
      req_if.req_valid = 1'b0;
      axi_if.ar_ready  = 1'b1;
      tick();
      axi_if.ar_ready  = 1'b0;
      check("mid_rst.in_rd_data", axi_if.r_ready, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst.r_ready", axi_if.r_ready, 1'b0);
      check("mid_rst.resp_valid", req_if.resp_valid, 1'b0);
      check("mid_rst.req_ready", req_if.req_ready, 1'b1);
      tick();
      reset = 1'b0;
      run_txn("post_rst", 1'b0, 64'h8000_0022, 64'd0, 2'd1, 1'b1, 64'h0000_0000_8001_0000, 2'd0,
              0, 0, 0, 0, 0, 0);
      check("post_rst.pin_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_8001);

      for (int t = 0; t < 60; t++) begin
         r_wen  = 1'($urandom_range(0, 1));
         r_size = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) r_off = $urandom_range(0, 7);
         else r_off = ($urandom_range(0, 7) >> r_size) << r_size;
         r_addr = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 8 + 64'(r_off);
         run_txn($sformatf("rnd%0d", t), r_wen, r_addr, {$urandom, $urandom}, r_size,
                 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
